// File: rtl/mvm_pkg.sv
`default_nettype none
//============================================================================
// mvm_pkg - sequencer state encoding and address-width helper for the MVM block
// Revision 1.0
//============================================================================
package mvm_pkg;

  typedef enum logic [2:0] {
    LOAD_MAT = 3'd0,
    LOAD_VEC = 3'd1,
    COMPUTE  = 3'd2,
    DRAIN    = 3'd3,
    OUTPUT   = 3'd4
  } state_t;

  // Width able to index n entries, never narrower than one bit.
  function automatic int safe_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mvm_wrap_cnt.sv
`default_nettype none
//============================================================================
// mvm_wrap_cnt - up counter wrapping at MAX-1 by compare, with sync clear
// Revision 1.0
//============================================================================
module mvm_wrap_cnt #(
  parameter int MAX = 4,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == W'(MAX - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mvm_seq_ctrl.sv
`default_nettype none
//============================================================================
// mvm_seq_ctrl - load/compute/output sequencer for the matrix-vector multiplier
// Revision 1.0
//============================================================================
module mvm_seq_ctrl
  import mvm_pkg::*;
#(
  parameter int M      = 4,
  parameter int N      = 4,
  parameter int MAT_AW = safe_w(M * N),
  parameter int VEC_AW = safe_w(N),
  parameter int ROW_W  = safe_w(M)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              mat_wr_en,
  output logic [MAT_AW-1:0] mat_wr_addr,
  output logic              vec_wr_en,
  output logic [VEC_AW-1:0] vec_wr_addr,
  output logic [MAT_AW-1:0] mat_rd_addr,
  output logic [VEC_AW-1:0] vec_rd_addr,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ROW_W-1:0]  out_row
);

  state_t state, state_nxt;
  logic   issue, out_hs, last_pass_hs;
  logic   mat_wr_last, vec_wr_last, col_last, row_last;

  assign s_ready      = (state == LOAD_MAT) || (state == LOAD_VEC);
  assign mat_wr_en    = s_valid && s_ready && (state == LOAD_MAT);
  assign vec_wr_en    = s_valid && s_ready && (state == LOAD_VEC);
  assign issue        = (state == COMPUTE);
  assign out_hs       = m_valid && m_ready;
  assign last_pass_hs = out_hs && row_last;

  mvm_wrap_cnt #(.MAX(M * N), .W(MAT_AW)) u_mat_wr (
    .clk(clk), .reset(reset), .en(mat_wr_en), .clr(1'b0),
    .cnt(mat_wr_addr), .tc(mat_wr_last)
  );

  mvm_wrap_cnt #(.MAX(N), .W(VEC_AW)) u_vec_wr (
    .clk(clk), .reset(reset), .en(vec_wr_en), .clr(1'b0),
    .cnt(vec_wr_addr), .tc(vec_wr_last)
  );

  mvm_wrap_cnt #(.MAX(N), .W(VEC_AW)) u_col (
    .clk(clk), .reset(reset), .en(issue), .clr(out_hs),
    .cnt(vec_rd_addr), .tc(col_last)
  );

  mvm_wrap_cnt #(.MAX(M), .W(ROW_W)) u_row (
    .clk(clk), .reset(reset), .en(out_hs), .clr(1'b0),
    .cnt(out_row), .tc(row_last)
  );

  // Running row*N+col address; it naturally lands on the next row's base.
  always_ff @(posedge clk) begin
    if (reset || last_pass_hs) begin
      mat_rd_addr <= '0;
    end else if (issue) begin
      mat_rd_addr <= (mat_rd_addr == MAT_AW'(M * N - 1)) ? '0 : mat_rd_addr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD_MAT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_MAT: if (mat_wr_en && mat_wr_last) state_nxt = LOAD_VEC;
      LOAD_VEC: if (vec_wr_en && vec_wr_last) state_nxt = COMPUTE;
      COMPUTE:  if (col_last)                 state_nxt = DRAIN;
      DRAIN:                                  state_nxt = OUTPUT;
      OUTPUT:   if (m_ready)                  state_nxt = row_last ? LOAD_MAT : COMPUTE;
      default:                                state_nxt = LOAD_MAT;
    endcase
  end

  // Accumulator controls trail the read issue by the memory read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_en  <= 1'b0;
      acc_clr <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      acc_en  <= issue;
      acc_clr <= issue && (vec_rd_addr == '0);
      m_valid <= (state_nxt == OUTPUT);
    end
  end

endmodule
`default_nettype wire
